// File: rtl/seven_segment_pkg.sv
// Shared definitions for the seven-segment display path: the digit-to-segment
// table (also used by the display driver), monitor FSM state encoding and a
// BCD successor helper.
package seven_segment_pkg;

    localparam int NUM_DIGITS = 10;

    // Segment patterns for digits 0..9, bit0 = top segment, bit6 = middle.
    localparam logic [6:0] SEG_TABLE [0:NUM_DIGITS-1] = '{
        7'b0111111,  // 0
        7'b0000110,  // 1
        7'b1011011,  // 2
        7'b1001111,  // 3
        7'b1100110,  // 4
        7'b1101101,  // 5
        7'b1111100,  // 6
        7'b0000111,  // 7
        7'b1111111,  // 8
        7'b1100111   // 9
    };

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } mon_state_e;

    // Next digit in the 0..9 counting order, wrapping 9 -> 0.
    function automatic logic [3:0] digit_successor(input logic [3:0] d);
        return (d >= 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

endpackage

// File: rtl/seven_segment_monitor_seg7_decode.sv
// Combinational segment-pattern decoder: maps a 7-bit pattern back to its
// digit and flags whether the pattern is one of the ten legal shapes.
module seg7_decode
    import seven_segment_pkg::*;
(
    input  logic [6:0] pattern,
    output logic       legal,
    output logic [3:0] digit
);

    // Search the shared table; anything not found (including blank) is illegal.
    always_comb begin
        legal = 1'b0;
        digit = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (pattern == SEG_TABLE[i]) begin
                legal = 1'b1;
                digit = 4'(i);
            end
        end
    end

endmodule

// File: rtl/seven_segment_monitor.sv
// Seconds-display monitor: glitch-filters the segment bus, decodes digits,
// checks 0..9 sequencing and measures the cycle period between digit steps.
// Optional macro SEG_MONITOR_SYNC_EN inserts a 2-flop input synchronizer for
// an asynchronous source (adds latency, period unaffected).
//
// state    | meaning
// IDLE     | no legal digit held
// ACQUIRE  | reference digit held, period not yet trusted
// TRACK    | in-sequence digits seen, period reported on every step
module seven_segment_monitor
    import seven_segment_pkg::*;
#(
    parameter int STABLE_CYCLES = 2,
    parameter int PERIOD_WIDTH  = 24
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              segments_in,
    input  logic                    clear_errors,
    output logic [3:0]              digit,
    output logic                    digit_valid,
    output logic [PERIOD_WIDTH-1:0] period,
    output logic                    period_valid,
    output logic                    seq_error,
    output logic                    pattern_error
);

    localparam logic [1:0] IDLE    = ST_IDLE;
    localparam logic [1:0] ACQUIRE = ST_ACQUIRE;
    localparam logic [1:0] TRACK   = ST_TRACK;
    localparam logic [PERIOD_WIDTH-1:0] GAP_MAX = '1;

    logic [6:0]              sample_src;
    logic [6:0]              s;
    logic [6:0]              cand;
    logic [6:0]              accepted;
    logic [3:0]              cnt;
    logic [4:0]              run;
    logic                    accept;
    logic [PERIOD_WIDTH-1:0] gap;
    logic [1:0]              state;
    logic                    dec_legal;
    logic [3:0]              dec_digit;

`ifdef SEG_MONITOR_SYNC_EN
    logic [6:0] sync_1;
    logic [6:0] sync_2;

    // Two-stage synchronizer for an off-chip or unrelated-clock segment bus.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_1 <= 7'd0;
            sync_2 <= 7'd0;
        end else begin
            sync_1 <= segments_in;
            sync_2 <= sync_1;
        end
    end

    assign sample_src = sync_2;
`else
    assign sample_src = segments_in;
`endif

    // run = number of consecutive cycles s has held its current value.
    assign run    = (s == cand) ? ({1'b0, cnt} + 5'd1) : 5'd1;
    assign accept = (run == 5'(STABLE_CYCLES)) && (s != accepted);

    seg7_decode u_decode (
        .pattern (s),
        .legal   (dec_legal),
        .digit   (dec_digit)
    );

    // Glitch filter: sample, track run length of the sample, latch accepted pattern.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s        <= 7'd0;
            cand     <= 7'd0;
            cnt      <= 4'd0;
            accepted <= 7'd0;
        end else begin
            s <= sample_src;
            if (s == cand) begin
                if (cnt != 4'hF) cnt <= cnt + 4'd1;
            end else begin
                cand <= s;
                cnt  <= 4'd1;
            end
            if (accept) accepted <= s;
        end
    end

    // Gap counter: cycles since the last accept, restarting at 1 so the value
    // seen on the next accept equals the accept-to-accept distance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gap <= '0;
        end else if (accept) begin
            gap <= PERIOD_WIDTH'(1);
        end else if (gap != GAP_MAX) begin
            gap <= gap + PERIOD_WIDTH'(1);
        end
    end

    // Sequencing FSM and registered outputs; an error set beats a same-cycle clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= IDLE;
            digit         <= 4'd0;
            digit_valid   <= 1'b0;
            period        <= '0;
            period_valid  <= 1'b0;
            seq_error     <= 1'b0;
            pattern_error <= 1'b0;
        end else begin
            period_valid <= 1'b0;
            if (clear_errors) begin
                seq_error     <= 1'b0;
                pattern_error <= 1'b0;
            end
            if (accept) begin
                if (!dec_legal) begin
                    pattern_error <= 1'b1;
                    digit_valid   <= 1'b0;
                    state         <= IDLE;
                end else begin
                    digit       <= dec_digit;
                    digit_valid <= 1'b1;
                    case (state)
                        IDLE: state <= ACQUIRE;
                        ACQUIRE, TRACK: begin
                            if (dec_digit == digit_successor(digit)) begin
                                state        <= TRACK;
                                period       <= gap;
                                period_valid <= 1'b1;
                            end else begin
                                seq_error <= 1'b1;
                                state     <= ACQUIRE;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_seven_segment_monitor.sv
// Self-checking bench for seven_segment_monitor. Stimulus is a list of held
// segment patterns; an event-level model predicts digit, flags and periods.
module tb_seven_segment_monitor;

    localparam int STABLE = 2;
`ifdef SEG_MONITOR_SYNC_EN
    localparam int LAT = STABLE + 3;
`else
    localparam int LAT = STABLE + 1;
`endif

    localparam logic [6:0] SEG_OF [0:9] = '{
        7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111, 7'b1100110,
        7'b1101101, 7'b1111100, 7'b0000111, 7'b1111111, 7'b1100111
    };

    logic        clk = 1'b0;
    logic        reset;
    logic [6:0]  segments_in;
    logic        clear_errors;

    logic [3:0]  digit, digit_8;
    logic        digit_valid, digit_valid_8;
    logic [23:0] period;
    logic [7:0]  period_8;
    logic        period_valid, period_valid_8;
    logic        seq_error, seq_error_8;
    logic        pattern_error, pattern_error_8;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // model state
    logic [6:0]  m_acc_pat;
    logic [3:0]  m_digit;
    logic        m_dv, m_seq, m_pat;
    logic [23:0] m_period;
    logic [7:0]  m_period8;
    int          m_last_t;
    int          exp_np;
    int          ob_np, ob_np8;

    seven_segment_monitor #(.STABLE_CYCLES(STABLE), .PERIOD_WIDTH(24)) dut (
        .clk(clk), .reset(reset), .segments_in(segments_in), .clear_errors(clear_errors),
        .digit(digit), .digit_valid(digit_valid), .period(period),
        .period_valid(period_valid), .seq_error(seq_error), .pattern_error(pattern_error)
    );

    seven_segment_monitor #(.STABLE_CYCLES(STABLE), .PERIOD_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .segments_in(segments_in), .clear_errors(clear_errors),
        .digit(digit_8), .digit_valid(digit_valid_8), .period(period_8),
        .period_valid(period_valid_8), .seq_error(seq_error_8), .pattern_error(pattern_error_8)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    function automatic int decode_ref(input logic [6:0] p);
        decode_ref = -1;
        for (int i = 0; i < 10; i++) if (SEG_OF[i] == p) decode_ref = i;
    endfunction

    task automatic model_reset();
        m_acc_pat = 7'd0; m_digit = 4'd0; m_dv = 1'b0; m_seq = 1'b0; m_pat = 1'b0;
        m_period = 24'd0; m_period8 = 8'd0; m_last_t = 0; exp_np = 0;
    endtask

    // One held pattern starting at cycle t: accepted if it differs from the
    // last accepted pattern; period is the distance between accept start times.
    task automatic model_seg(input logic [6:0] pat, input int hold, input int t);
        int d;
        int g;
        exp_np = 0;
        if (hold >= STABLE && pat != m_acc_pat) begin
            m_acc_pat = pat;
            d = decode_ref(pat);
            g = t - m_last_t;
            m_last_t = t;
            if (d < 0) begin
                m_pat = 1'b1;
                m_dv  = 1'b0;
            end else if (!m_dv) begin
                m_digit = 4'(d);
                m_dv    = 1'b1;
            end else if (d == (int'(m_digit) + 1) % 10) begin
                exp_np    = 1;
                m_digit   = 4'(d);
                m_period  = 24'(g);
                m_period8 = (g > 255) ? 8'd255 : 8'(g);
            end else begin
                m_seq   = 1'b1;
                m_digit = 4'(d);
            end
        end
    endtask

    // Hold pat for hold cycles, optional 1-cycle glitch at gpos and a
    // clear_errors pulse on iteration clr_at; counts period_valid pulses.
    task automatic drive_seg(input logic [6:0] pat, input int hold, input int gpos,
                             input logic [6:0] gpat, input int clr_at);
        int t0;
        t0 = cyc;
        ob_np = 0;
        ob_np8 = 0;
        for (int i = 0; i < hold; i++) begin
            segments_in  = (i == gpos) ? gpat : pat;
            clear_errors = (i == clr_at);
            @(posedge clk); #1;
            if (period_valid)   ob_np++;
            if (period_valid_8) ob_np8++;
        end
        segments_in  = pat;
        clear_errors = 1'b0;
        if (clr_at >= 0 && clr_at + 1 <= LAT) begin m_seq = 1'b0; m_pat = 1'b0; end
        model_seg(pat, hold, t0);
        if (clr_at >= 0 && clr_at + 1 > LAT) begin m_seq = 1'b0; m_pat = 1'b0; end
    endtask

    task automatic test_reset();
        reset = 1'b1; segments_in = 7'd0; clear_errors = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({digit, digit_valid, period, period_valid, seq_error, pattern_error} !== 32'd0)
            $display("FAIL reset_outputs: got %h expected 0",
                     {digit, digit_valid, period, period_valid, seq_error, pattern_error});
        else n_pass++;
        n_checks++;
        if ({digit_8, digit_valid_8, period_8, period_valid_8, seq_error_8, pattern_error_8} !== 16'd0)
            $display("FAIL reset_outputs_w8: got %h expected 0",
                     {digit_8, digit_valid_8, period_8, period_valid_8, seq_error_8, pattern_error_8});
        else n_pass++;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    task automatic test_sequence();
        for (int k = 0; k < 12; k++) begin
            drive_seg(SEG_OF[k % 10], 100, -1, 7'd0, -1);
            n_checks++;
            if ({digit, digit_valid, seq_error, pattern_error, 4'(ob_np), period} !==
                {m_digit, m_dv, m_seq, m_pat, 4'(exp_np), m_period})
                $display("FAIL seq_step%0d: got d=%0d v=%b se=%b pe=%b np=%0d per=%0d expected d=%0d v=%b se=%b pe=%b np=%0d per=%0d",
                         k, digit, digit_valid, seq_error, pattern_error, ob_np, period,
                         m_digit, m_dv, m_seq, m_pat, exp_np, m_period);
            else n_pass++;
        end
    endtask

    task automatic test_seq_error();
        int ds [4] = '{2, 3, 5, 6};
        for (int k = 0; k < 4; k++) begin
            drive_seg(SEG_OF[ds[k]], 100, -1, 7'd0, -1);
            n_checks++;
            if ({digit, digit_valid, seq_error, pattern_error, 4'(ob_np), period} !==
                {m_digit, m_dv, m_seq, m_pat, 4'(exp_np), m_period})
                $display("FAIL seqerr_step%0d: got d=%0d v=%b se=%b pe=%b np=%0d per=%0d expected d=%0d v=%b se=%b pe=%b np=%0d per=%0d",
                         k, digit, digit_valid, seq_error, pattern_error, ob_np, period,
                         m_digit, m_dv, m_seq, m_pat, exp_np, m_period);
            else n_pass++;
        end
        n_checks++;
        if (seq_error !== 1'b1) $display("FAIL seqerr_sticky: got %b expected 1", seq_error);
        else n_pass++;
    endtask

    task automatic test_glitch();
        int ds [9] = '{7, 8, 9, 0, 1, 2, 3, 4, 5};
        for (int k = 0; k < 9; k++) begin
            drive_seg(SEG_OF[ds[k]], 100, (ds[k] == 4) ? 50 : -1, SEG_OF[8], (k == 0) ? 1 : -1);
            n_checks++;
            if ({digit, digit_valid, seq_error, pattern_error, 4'(ob_np), period} !==
                {m_digit, m_dv, m_seq, m_pat, 4'(exp_np), m_period})
                $display("FAIL glitch_step%0d: got d=%0d v=%b se=%b pe=%b np=%0d per=%0d expected d=%0d v=%b se=%b pe=%b np=%0d per=%0d",
                         k, digit, digit_valid, seq_error, pattern_error, ob_np, period,
                         m_digit, m_dv, m_seq, m_pat, exp_np, m_period);
            else n_pass++;
        end
    endtask

    task automatic test_pattern_error();
        int ds [7] = '{6, 7, 8, 9, 0, 1, 2};
        for (int k = 0; k < 7; k++) drive_seg(SEG_OF[ds[k]], 30, -1, 7'd0, -1);
        n_checks++;
        if ({digit, period} !== {m_digit, m_period})
            $display("FAIL short_period: got d=%0d per=%0d expected d=%0d per=%0d", digit, period, m_digit, m_period);
        else n_pass++;
        drive_seg(7'b0000000, 10, -1, 7'd0, -1);
        n_checks++;
        if ({pattern_error, digit_valid, digit} !== {1'b1, 1'b0, 4'd2})
            $display("FAIL blank_accept: got pe=%b v=%b d=%0d expected pe=1 v=0 d=2", pattern_error, digit_valid, digit);
        else n_pass++;
        drive_seg(7'b0000000, 10, -1, 7'd0, 3);
        n_checks++;
        if ({pattern_error, m_pat} !== 2'b00)
            $display("FAIL clear_alone: got pe=%b expected 0", pattern_error);
        else n_pass++;
        drive_seg(7'b1001001, 10, -1, 7'd0, LAT - 1);
        n_checks++;
        if ({pattern_error, digit_valid, digit} !== {m_pat, m_dv, m_digit} || m_pat !== 1'b1)
            $display("FAIL clear_vs_set: got pe=%b v=%b d=%0d expected pe=1 v=0 d=%0d", pattern_error, digit_valid, digit, m_digit);
        else n_pass++;
    endtask

    task automatic test_saturation();
        int ds [3] = '{3, 4, 5};
        int hs [3] = '{100, 300, 100};
        for (int k = 0; k < 3; k++) begin
            drive_seg(SEG_OF[ds[k]], hs[k], -1, 7'd0, -1);
            n_checks++;
            if ({4'(ob_np8), period_8, digit_8} !== {4'(exp_np), m_period8, m_digit})
                $display("FAIL sat_w8_step%0d: got np=%0d per=%0d d=%0d expected np=%0d per=%0d d=%0d",
                         k, ob_np8, period_8, digit_8, exp_np, m_period8, m_digit);
            else n_pass++;
        end
        n_checks++;
        if ({period_8, period} !== {8'd255, 24'd300})
            $display("FAIL sat_value: got w8=%0d w24=%0d expected w8=255 w24=300", period_8, period);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        drive_seg(SEG_OF[6], 100, -1, 7'd0, -1);
        drive_seg(SEG_OF[7], 100, -1, 7'd0, -1);
        segments_in = SEG_OF[8];
        repeat (40) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({digit, digit_valid, period, period_valid, seq_error, pattern_error,
             digit_8, digit_valid_8, period_8, period_valid_8, seq_error_8, pattern_error_8} !== 48'd0)
            $display("FAIL reset_mid: got %h expected 0",
                     {digit, digit_valid, period, period_valid, seq_error, pattern_error,
                      digit_8, digit_valid_8, period_8, period_valid_8, seq_error_8, pattern_error_8});
        else n_pass++;
        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            drive_seg(SEG_OF[(8 + k) % 10], 100, -1, 7'd0, -1);
            n_checks++;
            if ({digit, digit_valid, 4'(ob_np), period} !== {m_digit, m_dv, 4'(exp_np), m_period})
                $display("FAIL post_reset_step%0d: got d=%0d v=%b np=%0d per=%0d expected d=%0d v=%b np=%0d per=%0d",
                         k, digit, digit_valid, ob_np, period, m_digit, m_dv, exp_np, m_period);
            else n_pass++;
        end
    endtask

    task automatic test_random();
        logic [6:0] p;
        int r, hold, gpos, clr;
        for (int k = 0; k < 40; k++) begin
            r = int'($urandom_range(0, 99));
            if (r < 60)      p = SEG_OF[(int'(m_digit) + 1) % 10];
            else if (r < 85) p = SEG_OF[$urandom_range(0, 9)];
            else begin
                do p = 7'($urandom_range(0, 127)); while (decode_ref(p) >= 0);
            end
            hold = int'($urandom_range(12, 160));
            gpos = ($urandom_range(0, 9) == 0) ? hold / 2 : -1;
            clr  = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 8)) : -1;
            drive_seg(p, hold, gpos, (p == SEG_OF[8]) ? SEG_OF[1] : SEG_OF[8], clr);
            n_checks++;
            if ({digit, digit_valid, seq_error, pattern_error, 4'(ob_np), period, 4'(ob_np8), period_8} !==
                {m_digit, m_dv, m_seq, m_pat, 4'(exp_np), m_period, 4'(exp_np), m_period8})
                $display("FAIL rand_seg%0d: got d=%0d v=%b se=%b pe=%b np=%0d per=%0d per8=%0d expected d=%0d v=%b se=%b pe=%b np=%0d per=%0d per8=%0d",
                         k, digit, digit_valid, seq_error, pattern_error, ob_np, period, period_8,
                         m_digit, m_dv, m_seq, m_pat, exp_np, m_period, m_period8);
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_seq_error();
        test_glitch();
        test_pattern_error();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
